// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display blocks: segment patterns,
// scanner FSM states and a width helper.
package seg7_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active-low (0 = segment lit).
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Scanner FSM: BLANK keeps every anode off, DRIVE lights the current digit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    if (bits < 1) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex-digit decoder: 4-bit value to active-low {g..a} pattern.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] pattern
);

  // Straight lookup of the sixteen glyphs.
  always_comb begin
    pattern = SEG_OFF;
    case (value)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit hex display driver for a shared segment bus.
// Each digit owns a slot of REFRESH_DIV clocks; the first BLANK_CYCLES of a
// slot keep all anodes off so the previous digit cannot ghost into the next.
// Inputs are captured once per frame (at the start of digit 0's slot) so a
// value changing mid-scan never shows a torn mixture of old and new digits.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 200000,
  parameter int BLANK_CYCLES = 2000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  lz_suppress,
  output logic [6:0]            s_sgmt,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int PW = clog2(REFRESH_DIV);
  localparam int IW = clog2(N_DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam bit            HAS_BLANK  = (BLANK_CYCLES > 0);
  // Output polarity: 1 means a 0 on the pin turns the segment/anode on.
  localparam bit            POL        = (ACTIVE_LOW != 0);

  // Scan position and FSM.
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  state_t        state;
  state_t        state_next;
  logic          slot_end;
  logic          frame_start;

  // Per-frame snapshot of the user inputs.
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   snap_en;
  logic                  snap_lz;

  // Snapshot as seen this cycle: on the capture cycle the incoming values are
  // used directly so digit 0 is correct even when there is no blanking window.
  logic [4*N_DIGITS-1:0] eff_digits;
  logic [N_DIGITS-1:0]   eff_dp;
  logic [N_DIGITS-1:0]   eff_en;
  logic                  eff_lz;

  logic [N_DIGITS-1:0]   suppress;
  logic                  zero_run;
  logic [3:0]            cur_value;
  logic [6:0]            cur_pattern;
  logic                  lit;

  // Next output values, already in active-low form before polarity is applied.
  logic [N_DIGITS-1:0]   an_lo;
  logic [6:0]            seg_lo;
  logic                  dp_lo;

  assign slot_end    = (presc == PRESC_LAST);
  assign frame_start = (presc == '0) && (idx == '0);

  // Prescaler: one count per clock, wrapping at the end of every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (slot_end) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Digit index: advances once per slot, wrapping after the leftmost digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (slot_end) begin
      if (idx == IDX_LAST) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Input snapshot: captured only at the start of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
      snap_lz     <= 1'b0;
    end else if (frame_start) begin
      snap_digits <= digits;
      snap_dp     <= dp_in;
      snap_en     <= digit_en;
      snap_lz     <= lz_suppress;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLANK;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: blank for the first BLANK_CYCLES of a slot, then drive.
  always_comb begin
    state_next = state;
    case (state)
      ST_BLANK: begin
        if (!HAS_BLANK || (presc == BLANK_LAST)) begin
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (HAS_BLANK && slot_end) begin
          state_next = ST_BLANK;
        end
      end
      default: state_next = ST_BLANK;
    endcase
  end

  // Effective snapshot with same-cycle bypass on the capture cycle.
  always_comb begin
    eff_digits = snap_digits;
    eff_dp     = snap_dp;
    eff_en     = snap_en;
    eff_lz     = snap_lz;
    if (frame_start) begin
      eff_digits = digits;
      eff_dp     = dp_in;
      eff_en     = digit_en;
      eff_lz     = lz_suppress;
    end
  end

  // Leading-zero suppression: walk down from the leftmost digit while every
  // digit seen so far is zero. Enables play no part; digit 0 always shows.
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run && (eff_digits[4*k +: 4] == 4'h0);
      suppress[k] = eff_lz && zero_run;
    end
  end

  hex_to_7seg u_decode (
    .value   (cur_value),
    .pattern (cur_pattern)
  );

  // Select the current digit and build the next pin values.
  always_comb begin
    cur_value   = eff_digits[{idx, 2'b00} +: 4];
    lit         = (state == ST_DRIVE) && eff_en[idx] && !suppress[idx];
    an_lo       = '1;
    seg_lo      = SEG_OFF;
    dp_lo       = 1'b1;
    if (lit) begin
      an_lo[idx] = 1'b0;
      seg_lo     = cur_pattern;
      dp_lo      = !eff_dp[idx];
    end
  end

  // Output registers with board polarity applied; reset forces everything off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an     <= {N_DIGITS{POL}};
      s_sgmt <= {7{POL}};
      dp     <= POL;
    end else begin
      an     <= POL ? an_lo  : ~an_lo;
      s_sgmt <= POL ? seg_lo : ~seg_lo;
      dp     <= POL ? dp_lo  : ~dp_lo;
    end
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised successor to the two-digit seven-segment controller. It time-multiplexes N hex digits onto one shared common-anode segment bus and derives its own refresh rate from the system clock, so no separate 500 Hz clock is needed. Each digit slot has an inter-digit blanking window to stop ghosting. Inputs are snapshotted once per frame so the display never tears, and the block adds per-digit enable, decimal points and leading-zero suppression. It sits between the datapath and the board's digit/segment pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (range 2..8).
REFRESH_DIV, 200000, system clocks per digit slot (≥ BLANK_CYCLES+2).
BLANK_CYCLES, 2000, clocks at the start of each slot with all anodes off (0 = no blanking).
ACTIVE_LOW, 1, 1 = segments/dp/anodes asserted low; 0 = asserted high.

Ports:
clk  in  1  system clock; the block's only clock.
rst  in  1  asynchronous, active-high reset.
digits  in  4*N_DIGITS  hex value per digit; digit k = digits[4k+3:4k]; digit 0 is rightmost.
dp_in  in  N_DIGITS  decimal point request per digit.
digit_en  in  N_DIGITS  1 = digit may be lit; 0 = digit always blank.
lz_suppress  in  1  1 = blank leading zeros.
s_sgmt  out  7  segments {g,f,e,d,c,b,a}, registered.
dp  out  1  decimal point, registered.
an  out  N_DIGITS  anode selects, one-hot when active, registered.

Behaviour:
- One clock (clk) and one reset (rst); rst is asynchronous and active-high.
- Reset, immediate and asynchronous:
  - prescaler = 0, idx = 0, FSM in BLANK.
  - snapshot cleared: digits = 0, dp = 0, digit_en = 0, lz = 0.
  - all outputs inactive: an all off, s_sgmt all off, dp off (all ones when ACTIVE_LOW = 1).
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. slot_end = (presc == REFRESH_DIV-1). On slot_end, idx advances and wraps N_DIGITS-1 → 0.
- Snapshot: loads digits, dp_in, digit_en and lz_suppress on frame_start = (presc == 0 && idx == 0). This includes the first clock after rst deasserts. Input changes at any other time take effect only from the next frame.
- FSM, two states:
  - BLANK: anodes off. Moves to DRIVE when presc == BLANK_CYCLES-1; if BLANK_CYCLES = 0, BLANK is never entered after reset (first clock goes straight to DRIVE).
  - DRIVE: drives digit idx. Moves to BLANK on slot_end when BLANK_CYCLES > 0; otherwise stays in DRIVE and idx advances.
- Digit k is lit in DRIVE only if snap_en[k] = 1 and it is not suppressed.
- Suppression: k ≥ 1, snap_lz = 1, and snapshot digits k..N_DIGITS-1 are all 0. Enable bits are ignored when evaluating zeros. Digit 0 is never suppressed.
- Lit digit: an[idx] active, s_sgmt = decode(value), dp active iff snap_dp[idx].
- Unlit digit or BLANK state: all anodes, segments and dp inactive.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - ACTIVE_LOW = 0 inverts all outputs.
- Latency: outputs are registered, so pins reflect state/idx/presc one clock later.
- Frame period = N_DIGITS*REFRESH_DIV clocks.
- Reset mid-frame: outputs go inactive at once. After release, the frame restarts at digit 0 with a fresh snapshot.

Decomposition:
- Package seg7_pkg:
  - segment pattern constants SEG_0..SEG_F and SEG_OFF (active-low encoding).
  - FSM state encoding: ST_BLANK, ST_DRIVE.
  - clog2 helper for the idx/prescaler widths.
- Sub-module hex_to_7seg: combinational, 4-bit value → 7-bit active-low pattern. Reused by other labs.
- Top: prescaler, idx counter, snapshot registers, LZ logic, FSM, output registers.

Test Plan:
(All cases use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1.)
1. Assert rst mid-cycle → same time step: an=1111, s_sgmt=1111111, dp=1. Hold 3 clocks → unchanged.
2. digits=16'h2945, digit_en=1111, lz=0, dp_in=0 → each 8-clock slot shows 2 clocks an=1111, then 6 clocks of:
   - an=1110, s_sgmt=0010010
   - an=1101, s_sgmt=0011001
   - an=1011, s_sgmt=0010000
   - an=0111, s_sgmt=0100100
   Frame period = 32 clocks.
3. digits=16'h0007, lz=1 → digit 0 shows 1111000; slots 1–3 keep an=1111. Then digits=16'h0000 → digit 0 shows 1000000, others blank.
4. Change digits from 16'h1234 to 16'hABCD during slot 2 → slots 2–3 still show 2, 1; the next frame shows D, C, B, A.
5. digit_en=0101, dp_in=0001 → an never selects digits 1 or 3; dp=0 only during digit 0 DRIVE, 1 otherwise.
6. Pulse rst during slot 2 of a frame → outputs inactive immediately. After release: an=1110 first appears at clock 3 (BLANK 2 clocks + 1 register).
